// File: rtl/gf180mcu_clkmon_pkg.sv
// Shared types and default constants for the clock activity monitor.
package gf180mcu_clkmon_pkg;

  localparam int unsigned DEF_WIN         = 256;
  localparam int unsigned DEF_CW          = 16;
  localparam int unsigned DEF_LO_LIM      = 60;
  localparam int unsigned DEF_HI_LIM      = 70;
  localparam int unsigned DEF_SYNC_STAGES = 2;

  // Measurement controller states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_e;

endpackage : gf180mcu_clkmon_pkg

// File: rtl/gf180mcu_sync_nff.sv
// N-flop synchronizer bringing an asynchronous level into the clk domain.
module gf180mcu_sync_nff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // Shift the raw input one stage further down the chain each cycle.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  // Synchronizer flops, cleared on reset so no stale level survives.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

endmodule : gf180mcu_sync_nff

// File: rtl/gf180mcu_clk_activity_monitor.sv
// Counts rising edges of a monitored clock over a fixed window of reference
// clock cycles and flags loss, under-frequency and over-frequency.
module gf180mcu_clk_activity_monitor
  import gf180mcu_clkmon_pkg::*;
#(
  parameter int WIN         = DEF_WIN,
  parameter int CW          = DEF_CW,
  parameter int LO_LIM      = DEF_LO_LIM,
  parameter int HI_LIM      = DEF_HI_LIM,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic          CLK,
  input  logic          RN,
  input  logic          EN,
  input  logic          MI,
  output logic [CW-1:0] CNT,
  output logic          VALID,
  output logic          LOSS,
  output logic          LOW,
  output logic          HIGH
);

  localparam int WCW = $clog2(WIN);
  localparam int ACW = $clog2(SYNC_STAGES + 1);

  localparam logic [WCW-1:0] WC_LAST  = WCW'(WIN - 1);
  localparam logic [ACW-1:0] ARM_LAST = ACW'(SYNC_STAGES - 1);
  localparam logic [CW-1:0]  CNT_MAX  = '1;
  localparam logic [CW-1:0]  LO_THR   = CW'(LO_LIM);
  localparam logic [CW-1:0]  HI_THR   = CW'(HI_LIM);

  state_e         state_q, state_d;
  logic [ACW-1:0] arm_q, arm_d;
  logic [WCW-1:0] wc_q, wc_d;
  logic [CW-1:0]  ec_q, ec_d;
  logic           s_prev_q, s_prev_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           valid_q, valid_d;
  logic           loss_q, loss_d;
  logic           low_q, low_d;
  logic           high_q, high_d;

  logic           s;
  logic           e;
  logic [CW-1:0]  ec_sat;

  gf180mcu_sync_nff #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (CLK),
    .rst_n (RN),
    .d     (MI),
    .q     (s)
  );

  // Rising-edge detect on the synchronized clock and saturating increment.
  always_comb begin
    e      = s & ~s_prev_q;
    ec_sat = (ec_q == CNT_MAX) ? ec_q : ec_q + CW'(e);
  end

  // Next-state logic for the controller, counters and result registers.
  always_comb begin
    // NOTE: every variable gets a default first, otherwise a path that skips it infers a latch.
    state_d  = state_q;
    arm_d    = arm_q;
    wc_d     = wc_q;
    ec_d     = ec_q;
    s_prev_d = s;
    cnt_d    = cnt_q;
    loss_d   = loss_q;
    low_d    = low_q;
    high_d   = high_q;
    valid_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        arm_d = '0;
        wc_d  = '0;
        ec_d  = '0;
        if (EN) state_d = ARM;
      end

      // Let the synchronizer flush whatever it held before counting starts.
      ARM: begin
        if (!EN) begin
          state_d = IDLE;
          arm_d   = '0;
        end else if (arm_q == ARM_LAST) begin
          state_d = MEASURE;
          arm_d   = '0;
          wc_d    = '0;
          ec_d    = '0;
        end else begin
          arm_d = arm_q + 1'b1;
        end
      end

      MEASURE: begin
        if (!EN) begin
          // Partial window is dropped; published results stay as they were.
          state_d = IDLE;
          wc_d    = '0;
          ec_d    = '0;
        end else if (wc_q == WC_LAST) begin
          // The edge seen on the last cycle still belongs to this window.
          cnt_d   = ec_sat;
          loss_d  = (ec_sat == '0);
          low_d   = (ec_sat < LO_THR);
          high_d  = (ec_sat > HI_THR);
          valid_d = 1'b1;
          wc_d    = '0;
          ec_d    = '0;
        end else begin
          wc_d = wc_q + 1'b1;
          ec_d = ec_sat;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State, counter and result registers.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q  <= IDLE;
      arm_q    <= '0;
      wc_q     <= '0;
      ec_q     <= '0;
      s_prev_q <= 1'b0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      loss_q   <= 1'b0;
      low_q    <= 1'b0;
      high_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      arm_q    <= arm_d;
      wc_q     <= wc_d;
      ec_q     <= ec_d;
      s_prev_q <= s_prev_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      loss_q   <= loss_d;
      low_q    <= low_d;
      high_q   <= high_d;
    end
  end

  assign CNT   = cnt_q;
  assign VALID = valid_q;
  assign LOSS  = loss_q;
  assign LOW   = low_q;
  assign HIGH  = high_q;

endmodule : gf180mcu_clk_activity_monitor
